// File: rtl/alu_nibble_sequencer_pkg.sv
// Shared types for the nibble-serial ALU sequencer: slice function codes,
// controller states and the arithmetic-op classifier.
package alu_nibble_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_CLR = 3'b000,
    OP_BMA = 3'b001,
    OP_AMB = 3'b010,
    OP_ADD = 3'b011,
    OP_XOR = 3'b100,
    OP_OR  = 3'b101,
    OP_AND = 3'b110,
    OP_SET = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Only the add/subtract functions chain a carry or borrow between nibbles.
  function automatic logic op_is_arith(alu_op_e op);
    return (op == OP_BMA) || (op == OP_AMB) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/alu_nibble_sequencer_if.sv
// Request/response handshake plus the 74x381 slice pins, grouped as one bundle.
// master = requester and slice side, slave = the sequencer.
interface alu_nibble_sequencer_if
  import alu_nibble_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             req_valid;
  logic             req_ready;
  alu_op_e          req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_cin;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_f;
  logic             rsp_cout;
  logic             rsp_zero;

  logic [3:0]       sl_a;
  logic [3:0]       sl_b;
  alu_op_e          sl_s;
  logic             sl_cn;
  logic [3:0]       sl_f;
  logic             sl_gn;
  logic             sl_pn;

  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, rsp_ready, sl_f, sl_gn, sl_pn,
    input  req_ready, rsp_valid, rsp_f, rsp_cout, rsp_zero, sl_a, sl_b, sl_s, sl_cn
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready, sl_f, sl_gn, sl_pn,
    output req_ready, rsp_valid, rsp_f, rsp_cout, rsp_zero, sl_a, sl_b, sl_s, sl_cn
  );

endinterface

// File: rtl/alu_nibble_sequencer_carry_step.sv
// One ripple step of the carry/borrow chain built from the slice's active-low
// group generate/propagate; logical functions never produce a carry.
module alu_nibble_sequencer_carry_step
  import alu_nibble_sequencer_pkg::*;
(
  input  logic    gn_i,
  input  logic    pn_i,
  input  logic    cin_i,
  input  alu_op_e op_i,
  output logic    cout_o
);

  assign cout_o = op_is_arith(op_i) & (~gn_i | (~pn_i & cin_i));

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Drives one external 4-bit slice LSB nibble first, rippling carry/borrow
// through a register, and returns the WIDTH-bit result on a valid/ready pair.
module alu_nibble_sequencer
  import alu_nibble_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  alu_nibble_sequencer_if.slave seq_io
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  alu_op_e          op_q, op_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept;
  logic last_nibble;
  logic carry_next;

  assign accept      = (state_q == ST_IDLE) && seq_io.req_valid;
  assign last_nibble = (cnt_q == CNT_W'(NIBBLES - 1));

  alu_nibble_sequencer_carry_step u_carry_step (
    .gn_i   (seq_io.sl_gn),
    .pn_i   (seq_io.sl_pn),
    .cin_i  (carry_q),
    .op_i   (op_q),
    .cout_o (carry_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation order cannot change behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)                               state_d = ST_BUSY;
      ST_BUSY: if (last_nibble)                          state_d = ST_DONE;
      ST_DONE: if (seq_io.rsp_ready)                     state_d = ST_IDLE;
      default:                                           state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    op_d    = op_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_sh_d  = seq_io.req_a;
          b_sh_d  = seq_io.req_b;
          op_d    = seq_io.req_op;
          carry_d = op_is_arith(seq_io.req_op) & seq_io.req_cin;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        res_d   = {seq_io.sl_f, res_q[WIDTH-1:4]};
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        carry_d = carry_next;
        cnt_d   = cnt_q + CNT_W'(1);
        // Flag registered once so it stays put through DONE and reads 0 after reset.
        if (last_nibble) zero_d = (res_d == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      op_q    <= OP_CLR;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    seq_io.req_ready = (state_q == ST_IDLE);
    seq_io.rsp_valid = (state_q == ST_DONE);
    seq_io.rsp_f     = res_q;
    seq_io.rsp_cout  = carry_q;
    seq_io.rsp_zero  = zero_q;
    seq_io.sl_a      = '0;
    seq_io.sl_b      = '0;
    seq_io.sl_s      = OP_CLR;
    seq_io.sl_cn     = 1'b0;
    if (state_q == ST_BUSY) begin
      seq_io.sl_a  = a_sh_q[3:0];
      seq_io.sl_b  = b_sh_q[3:0];
      seq_io.sl_s  = op_q;
      seq_io.sl_cn = carry_q;
    end
  end

endmodule
